// File: rtl/ac97_frame_rx.sv
// AC'97 serial-input receiver. It oversamples the codec bit clock in the system clock
// domain, frames the 256-bit stream and extracts the slot 3/4 PCM capture samples.
// It also keeps a peak-hold magnitude of the left channel.
module ac97_frame_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        BitClk,
    input  logic        Sync,
    input  logic        SData,
    input  logic        ClearPeak,
    output logic [19:0] LeftSample,
    output logic [19:0] RightSample,
    output logic        SampleValid,
    output logic        CodecReady,
    output logic [19:0] PeakMag,
    output logic        FrameError
);

    typedef enum logic {HUNT, RUN} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0] sync_sync_q, sync_sync_d;
    logic [SYNC_STAGES-1:0] sdat_sync_q, sdat_sync_d;
    logic                   bclk_prev_q, bclk_prev_d;
    logic                   sync_prev_q, sync_prev_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [15:0]            tag_q, tag_d;
    logic [19:0]            left_sr_q, left_sr_d;
    logic [19:0]            right_sr_q, right_sr_d;
    logic signed [19:0]     left_q, left_d;
    logic signed [19:0]     right_q, right_d;
    logic                   valid_q, valid_d;
    logic                   ready_q, ready_d;
    logic                   ferr_q, ferr_d;
    logic [19:0]            peak_q, peak_d;

    logic       bclk_s, sync_s, sdat_s;
    logic       strobe, frame_start;
    logic       bit_en, resync, commit;
    logic [7:0] idx;
    logic [19:0] right_new;
    logic [19:0] mag;

    // |x| for a 20-bit two's complement sample; the most negative value saturates.
    function automatic logic [19:0] sat_abs(input logic signed [19:0] x);
        logic signed [19:0] neg;
        neg = -x;
        if (x == $signed({1'b1, 19'b0}))
            return 20'h7FFFF;
        else if (x[19])
            return neg;
        else
            return x;
    endfunction

    assign bclk_s      = bclk_sync_q[SYNC_STAGES-1];
    assign sync_s      = sync_sync_q[SYNC_STAGES-1];
    assign sdat_s      = sdat_sync_q[SYNC_STAGES-1];
    assign strobe      = bclk_prev_q & ~bclk_s;
    assign frame_start = strobe & sync_s & ~sync_prev_q;

    // Equal-depth synchronizers keep BitClk, Sync and SData mutually aligned.
    always_comb begin
        bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], BitClk};
        sync_sync_d = {sync_sync_q[SYNC_STAGES-2:0], Sync};
        sdat_sync_d = {sdat_sync_q[SYNC_STAGES-2:0], SData};
        bclk_prev_d = bclk_s;
    end

    // Framing FSM: find the first sync edge, then count bits and flag bad frame lengths.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sync_prev_d = sync_prev_q;
        bit_en      = 1'b0;
        resync      = 1'b0;
        idx         = cnt_q;
        if (strobe) begin
            sync_prev_d = sync_s;
            case (state_q)
                HUNT: begin
                    if (frame_start) begin
                        state_d = RUN;
                        idx     = 8'd0;
                        bit_en  = 1'b1;
                    end
                end
                RUN: begin
                    bit_en = 1'b1;
                    if (frame_start) begin
                        idx    = 8'd0;
                        resync = (cnt_q != 8'd255);
                    end else begin
                        idx = cnt_q + 8'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
            if (bit_en)
                cnt_d = idx;
        end
    end

    // Slot capture, sample commit at bit 95 and left-channel peak hold.
    always_comb begin
        tag_d      = tag_q;
        left_sr_d  = left_sr_q;
        right_sr_d = right_sr_q;
        left_d     = left_q;
        right_d    = right_q;
        valid_d    = 1'b0;
        ready_d    = ready_q;
        ferr_d     = ferr_q | resync;
        peak_d     = peak_q;
        commit     = 1'b0;
        right_new  = {right_sr_q[18:0], sdat_s};
        mag        = sat_abs($signed(left_sr_q));
        if (bit_en) begin
            if (resync) begin
                left_sr_d  = '0;
                right_sr_d = '0;
            end
            if (idx < 8'd16)
                tag_d = {tag_q[14:0], sdat_s};
            if (idx == 8'd15)
                ready_d = tag_q[14];
            if (idx >= 8'd56 && idx <= 8'd75)
                left_sr_d = {left_sr_q[18:0], sdat_s};
            if (idx >= 8'd76 && idx <= 8'd95)
                right_sr_d = right_new;
            if (idx == 8'd95 && tag_q[15] && tag_q[12] && tag_q[11])
                commit = 1'b1;
        end
        if (commit) begin
            left_d  = $signed(left_sr_q);
            right_d = $signed(right_new);
            valid_d = 1'b1;
        end
        if (ClearPeak)
            peak_d = commit ? mag : 20'd0;
        else if (commit && mag > peak_q)
            peak_d = mag;
    end

    // State register; reset returns everything, including the synchronizers, to zero.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= HUNT;
            bclk_sync_q <= '0;
            sync_sync_q <= '0;
            sdat_sync_q <= '0;
            bclk_prev_q <= 1'b0;
            sync_prev_q <= 1'b0;
            cnt_q       <= '0;
            tag_q       <= '0;
            left_sr_q   <= '0;
            right_sr_q  <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b0;
            ferr_q      <= 1'b0;
            peak_q      <= '0;
        end else begin
            state_q     <= state_d;
            bclk_sync_q <= bclk_sync_d;
            sync_sync_q <= sync_sync_d;
            sdat_sync_q <= sdat_sync_d;
            bclk_prev_q <= bclk_prev_d;
            sync_prev_q <= sync_prev_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            left_sr_q   <= left_sr_d;
            right_sr_q  <= right_sr_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            ferr_q      <= ferr_d;
            peak_q      <= peak_d;
        end
    end

    assign LeftSample  = left_q;
    assign RightSample = right_q;
    assign SampleValid = valid_q;
    assign CodecReady  = ready_q;
    assign PeakMag     = peak_q;
    assign FrameError  = ferr_q;

endmodule

// File: tb/tb_ac97_frame_rx.sv
// Bench for ac97_frame_rx: a codec model shifts whole frames in on BitClk, and a
// frame-level reference model predicts samples, peak, ready and error flags.
`timescale 1ns/1ps
module tb_ac97_frame_rx;

    localparam int N = 2;

    logic        Clock = 1'b0;
    logic        Reset, BitClk, Sync, SData, ClearPeak;
    logic [19:0] LeftSample, RightSample, PeakMag;
    logic        SampleValid, CodecReady, FrameError;

    int checks = 0;
    int errors = 0;
    int sv_cnt = 0;

    logic [19:0] m_left = '0, m_right = '0, m_peak = '0;
    logic        m_ready = 1'b0, m_ferr = 1'b0;
    int          m_pulses = 0;

    event bit95_ev;

    ac97_frame_rx #(.SYNC_STAGES(N)) dut (
        .Clock(Clock), .Reset(Reset), .BitClk(BitClk), .Sync(Sync), .SData(SData),
        .ClearPeak(ClearPeak), .LeftSample(LeftSample), .RightSample(RightSample),
        .SampleValid(SampleValid), .CodecReady(CodecReady), .PeakMag(PeakMag),
        .FrameError(FrameError)
    );

    // 33 MHz system clock (30 ns); posedges at 15 + 30k.
    always #15 Clock = ~Clock;

    // Count cycles with SampleValid high, sampled away from the active edge.
    always @(negedge Clock) if (SampleValid === 1'b1) sv_cnt++;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    // |x| of a 20-bit two's complement value, computed on integers, capped at 0x7FFFF.
    function automatic logic [19:0] abs_mag(input logic [19:0] x);
        int v;
        v = x[19] ? int'(x) - 1048576 : int'(x);
        if (v < 0) v = -v;
        if (v > 524287) v = 524287;
        return v[19:0];
    endfunction

    // Frame-level prediction for one frame that got past bit 95.
    task automatic expect_frame(input logic [15:0] tag, input logic [19:0] l,
                                input logic [19:0] r, input bit clr);
        logic [19:0] mg;
        m_ready = tag[15];
        if (tag[15] && tag[12] && tag[11]) begin
            m_left  = l;
            m_right = r;
            m_pulses++;
            mg = abs_mag(l);
            if (clr) m_peak = mg;
            else if (mg > m_peak) m_peak = mg;
        end
    endtask

    task automatic check_all(input string nm);
        chk({nm, ".left"},  LeftSample,  m_left);
        chk({nm, ".right"}, RightSample, m_right);
        chk({nm, ".ready"}, CodecReady,  m_ready);
        chk({nm, ".peak"},  PeakMag,     m_peak);
        chk({nm, ".ferr"},  FrameError,  m_ferr);
        chk({nm, ".pulses"}, sv_cnt,     m_pulses);
        chk({nm, ".valid_idle"}, SampleValid, 1'b0);
    endtask

    // Codec model: data and Sync change on BitClk rise, DUT samples on the fall.
    // Half period 45 ns keeps every BitClk edge 5 ns off a Clock edge.
    task automatic send_frame(input logic [15:0] tag, input logic [19:0] l, input logic [19:0] r,
                              input int nbits, input bit with_sync, input int rst_at);
        bit b [256];
        for (int i = 0; i < 256; i++) b[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) b[i] = tag[15-i];
        for (int i = 0; i < 20; i++) begin
            b[56+i] = l[19-i];
            b[76+i] = r[19-i];
        end
        for (int i = 0; i < nbits; i++) begin
            SData  = b[i];
            Sync   = with_sync && (i < 16);
            BitClk = 1'b1;
            if (i == rst_at) Reset = 1'b1;
            #45;
            BitClk = 1'b0;
            Reset  = 1'b0;
            if (i == 95) ->bit95_ev;
            #45;
        end
    endtask

    function automatic logic [15:0] rand_tag();
        logic [15:0] t;
        t     = 16'($urandom);
        t[15] = ($urandom_range(0, 3) != 0);
        t[12] = ($urandom_range(0, 3) != 0);
        t[11] = ($urandom_range(0, 3) != 0);
        return t;
    endfunction

    initial begin
        logic [15:0] tag;
        logic [19:0] l, r;
        Reset = 1'b1; BitClk = 1'b0; Sync = 1'b0; SData = 1'b0; ClearPeak = 1'b0;
        #95;
        chk("rst.left",  LeftSample,  20'd0);
        chk("rst.right", RightSample, 20'd0);
        chk("rst.valid", SampleValid, 1'b0);
        chk("rst.ready", CodecReady,  1'b0);
        chk("rst.peak",  PeakMag,     20'd0);
        chk("rst.ferr",  FrameError,  1'b0);
        Reset = 1'b0;
        #90;

        // Three back-to-back valid frames (ready, slot 3 and 4 valid).
        for (int k = 0; k < 3; k++) begin
            send_frame(16'h9800, 20'h12345, 20'hFEDCB, 256, 1'b1, -1);
            expect_frame(16'h9800, 20'h12345, 20'hFEDCB, 1'b0);
            check_all($sformatf("basic%0d", k));
        end

        // Slot 4 invalid: samples hold, no pulse, codec still ready.
        send_frame(16'h9000, 20'h0ABCD, 20'h01234, 256, 1'b1, -1);
        expect_frame(16'h9000, 20'h0ABCD, 20'h01234, 1'b0);
        check_all("slot4_invalid");

        // ClearPeak alone, between frames.
        ClearPeak = 1'b1; #30; ClearPeak = 1'b0; #60;
        m_peak = '0;
        chk("clear_alone.peak", PeakMag, m_peak);

        // Peak sequence including the most negative sample.
        send_frame(16'h9800, 20'hFFF00, 20'h00001, 256, 1'b1, -1);
        expect_frame(16'h9800, 20'hFFF00, 20'h00001, 1'b0);
        check_all("peak_a");
        send_frame(16'h9800, 20'h00050, 20'h00002, 256, 1'b1, -1);
        expect_frame(16'h9800, 20'h00050, 20'h00002, 1'b0);
        check_all("peak_b");
        send_frame(16'h9800, 20'h80000, 20'h00003, 256, 1'b1, -1);
        expect_frame(16'h9800, 20'h80000, 20'h00003, 1'b0);
        check_all("peak_c");
        chk("peak_c.sat", PeakMag, 20'h7FFFF);

        // ClearPeak held so it overlaps the commit cycle: peak restarts from this sample.
        fork
            send_frame(16'hF800, 20'h00020, 20'h00004, 256, 1'b1, -1);
            begin
                @(bit95_ev);
                ClearPeak = 1'b1;
                repeat (N + 1) @(posedge Clock);
                #1 ClearPeak = 1'b0;
            end
        join
        expect_frame(16'hF800, 20'h00020, 20'h00004, 1'b1);
        check_all("clear_commit");

        // Free-running frame with no sync pulse is still decoded.
        l = 20'($urandom); r = 20'($urandom);
        send_frame(16'h9800, l, r, 256, 1'b0, -1);
        expect_frame(16'h9800, l, r, 1'b0);
        check_all("freerun");

        // Randomized frames.
        for (int k = 0; k < 8; k++) begin
            tag = rand_tag(); l = 20'($urandom); r = 20'($urandom);
            send_frame(tag, l, r, 256, 1'b1, -1);
            expect_frame(tag, l, r, 1'b0);
            check_all($sformatf("rand%0d", k));
        end

        // 200-bit frame, then a sync edge: sticky frame error, next frame still commits.
        l = 20'($urandom); r = 20'($urandom);
        send_frame(16'h9800, l, r, 200, 1'b1, -1);
        expect_frame(16'h9800, l, r, 1'b0);
        check_all("short");
        send_frame(16'h9800, 20'h00010, 20'h00005, 256, 1'b1, -1);
        m_ferr = 1'b1;
        expect_frame(16'h9800, 20'h00010, 20'h00005, 1'b0);
        check_all("resync");
        tag = rand_tag(); l = 20'($urandom); r = 20'($urandom);
        send_frame(tag, l, r, 256, 1'b1, -1);
        expect_frame(tag, l, r, 1'b0);
        check_all("after_resync");

        // Reset at bit 70 of a valid frame: everything clears and that frame never commits.
        send_frame(16'h9800, 20'h54321, 20'h0FEDC, 256, 1'b1, 70);
        m_left = '0; m_right = '0; m_peak = '0; m_ready = 1'b0; m_ferr = 1'b0;
        check_all("midreset");
        l = 20'($urandom); r = 20'($urandom);
        send_frame(16'h9800, l, r, 256, 1'b1, -1);
        expect_frame(16'h9800, l, r, 1'b0);
        check_all("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
